data_sram_slave: RTL and testbench

Responder end of the CPU data SRAM interface: a synchronous, word-wide, byte-writable single-port RAM answering data_sram_en/we/addr/wdata with data_sram_rdata. It sits outside the CPU core and gives the MEM stage its data memory. It adds a configurable read-pipeline depth, out-of-range detection and access statistics for bring-up and verification.

---
 rtl/data_sram_slave.sv | 113 +++++++++++
 tb/tb_data_sram_slave.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_slave.sv
// Byte-writable single-port data SRAM responder with a 1- or 2-stage read pipeline,
// out-of-range detection and access counters.
module data_sram_slave #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        oor_access,
    output logic [15:0] err_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("data_sram_slave: RD_LATENCY must be 1 or 2");
    end
    if (BASE_ADDR[ADDR_WIDTH+1:0] != '0) begin : g_bad_base
        $error("data_sram_slave: BASE_ADDR not aligned to the memory size");
    end

    logic [31:0]           mem [Depth];
    logic [31:0]           offset;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] index;
    logic                  access;
    logic                  oor;
    logic [3:0]            byte_wr;

    logic [31:0] rd1_q, rd1_d;
    logic        oor_q, oor_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        offset   = data_sram_addr - BASE_ADDR;
        in_range = (offset[31:ADDR_WIDTH+2] == '0);
        index    = offset[ADDR_WIDTH+1:2];
        // Gating by en first keeps X on addr/we from leaking into state while idle.
        access   = data_sram_en && in_range;
        oor      = data_sram_en && !in_range;
        byte_wr  = access ? data_sram_we : 4'b0000;
    end

    // The array has no reset so contents survive it; the edge seeing reset high writes nothing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_wr[i]) begin
                    mem[index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd1_d     = rd1_q;
        oor_d     = oor;
        err_cnt_d = err_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        if (access) begin
            rd1_d = mem[index];
        end else if (oor) begin
            rd1_d = 32'h0;
        end
        if (oor && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
        if (access && data_sram_we != 4'b0000) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1_q     <= 32'h0;
            oor_q     <= 1'b0;
            err_cnt_q <= 16'h0;
            wr_cnt_q  <= 32'h0;
        end else begin
            rd1_q     <= rd1_d;
            oor_q     <= oor_d;
            err_cnt_q <= err_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [31:0] rd2_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd2_q <= 32'h0;
            end else begin
                rd2_q <= rd1_q;
            end
        end
        assign data_sram_rdata = rd2_q;
    end else begin : g_lat1
        assign data_sram_rdata = rd1_q;
    end

    assign oor_access = oor_q;
    assign err_cnt    = err_cnt_q;
    assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed bench for data_sram_slave: one instance per read latency, sharing stimulus.
module tb_data_sram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rdata1, rdata2;
    logic        oor1, oor2;
    logic [15:0] err1, err2;
    logic [31:0] wr1, wr2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_sram_slave #(.ADDR_WIDTH(12), .RD_LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata1),
        .oor_access      (oor1),
        .err_cnt         (err1),
        .wr_cnt          (wr1)
    );

    data_sram_slave #(.ADDR_WIDTH(12), .RD_LATENCY(2), .BASE_ADDR(32'h0)) u_dut2 (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata2),
        .oor_access      (oor2),
        .err_cnt         (err2),
        .wr_cnt          (wr2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d);
        en    = e;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        #2;
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_rdata2", rdata2, 32'h0);
        chk("rst_oor", {31'h0, oor1}, 32'h0);
        chk("rst_err", {16'h0, err1}, 32'h0);
        chk("rst_wr", wr1, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Basic write then read
        drive(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        tick();
        chk("wr_cnt_1", wr1, 32'd1);
        chk("wr_oor", {31'h0, oor1}, 32'h0);
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        chk("rd_lat1", rdata1, 32'hDEADBEEF);
        chk("rd_wr_cnt", wr1, 32'd1);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("rd_hold1", rdata1, 32'hDEADBEEF);
        chk("rd_lat2", rdata2, 32'hDEADBEEF);

        // Byte enables
        drive(1'b1, 4'hF, 32'h20, 32'h11223344);
        tick();
        drive(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
        tick();
        drive(1'b1, 4'h0, 32'h20, 32'h0);
        tick();
        chk("byte_we", rdata1, 32'h11BB33DD);
        chk("byte_wr_cnt", wr1, 32'd3);

        // Read-first on same-cycle write
        drive(1'b1, 4'hF, 32'h30, 32'h12345678);
        tick();
        drive(1'b1, 4'hF, 32'h30, 32'h55555555);
        tick();
        chk("read_first", rdata1, 32'h12345678);
        drive(1'b1, 4'h0, 32'h30, 32'h0);
        tick();
        chk("read_after", rdata1, 32'h55555555);
        chk("rf_wr_cnt", wr1, 32'd5);

        // Two-stage latency
        drive(1'b1, 4'hF, 32'h10, 32'hCAFEF00D);
        tick();
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        chk("lat2_edgeN_l1", rdata1, 32'hCAFEF00D);
        chk("lat2_edgeN_l2", rdata2, 32'hDEADBEEF);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("lat2_edgeN1", rdata2, 32'hCAFEF00D);
        tick();
        chk("lat2_hold", rdata2, 32'hCAFEF00D);

        // Out of range: 0x4000 would alias word 0 if the range check were missing
        drive(1'b1, 4'hF, 32'h0, 32'h0BADF00D);
        tick();
        drive(1'b1, 4'h0, 32'h4000, 32'h0);
        tick();
        chk("oor_rdata", rdata1, 32'h0);
        chk("oor_pulse", {31'h0, oor1}, 32'h1);
        chk("oor_err1", {16'h0, err1}, 32'd1);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("oor_pulse_end", {31'h0, oor1}, 32'h0);
        chk("oor_err_hold", {16'h0, err1}, 32'd1);
        drive(1'b1, 4'hF, 32'h4000, 32'hFFFFFFFF);
        tick();
        chk("oor_wr_err", {16'h0, err1}, 32'd2);
        chk("oor_wr_cnt", wr1, 32'd7);
        drive(1'b1, 4'h0, 32'h0, 32'h0);
        tick();
        chk("oor_no_write", rdata1, 32'h0BADF00D);

        // X on controls while idle
        en    = 1'b0;
        we    = 4'bxxxx;
        addr  = 32'hxxxxxxxx;
        wdata = 32'hxxxxxxxx;
        tick();
        chk("x_wr_cnt", wr1, 32'd7);
        chk("x_err", {16'h0, err1}, 32'd2);
        chk("x_rdata", rdata1, 32'h0BADF00D);
        chk("x_oor", {31'h0, oor1}, 32'h0);
        drive(1'b1, 4'h0, 32'h0, 32'h0);
        tick();
        chk("x_mem", rdata1, 32'h0BADF00D);

        // Saturation
        drive(1'b1, 4'h0, 32'hFFFFFFFC, 32'h0);
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        chk("err_sat", {16'h0, err1}, 32'h0000FFFF);
        tick();
        chk("err_sat_hold", {16'h0, err2}, 32'h0000FFFF);

        // Reset mid-burst
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        drive(1'b1, 4'h0, 32'hFFFF0000, 32'h0);
        tick();
        chk("burst_oor", {31'h0, oor1}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_rd1", rdata1, 32'h0);
        chk("mid_rst_rd2", rdata2, 32'h0);
        chk("mid_rst_oor", {31'h0, oor1}, 32'h0);
        chk("mid_rst_err", {16'h0, err1}, 32'h0);
        chk("mid_rst_wr", wr2, 32'h0);
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_rd", rdata1, 32'hCAFEF00D);
        chk("post_rst_wr", wr1, 32'h0);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("post_rst_rd2", rdata2, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
